// File: rtl/tree_sprite_fetch.sv
// Three-stage sprite pixel fetch: hit/address, RAM align, palette output.
// Optional TREE_FETCH_MIRROR_EN adds a per-frame horizontal mirror input.
module tree_sprite_fetch #(
  parameter int          SPR_W  = 80,
  parameter int          SPR_H  = 100,
  parameter logic [3:0]  TRANSP = 4'h0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank_n,
  input  logic        frame_start,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic        sprite_en,
`ifdef TREE_FETCH_MIRROR_EN
  input  logic        mirror,
`endif
  output logic [12:0] read_address,
  input  logic [3:0]  data_Out,
  output logic [3:0]  pixel_index,
  output logic        pixel_on
);

  logic [9:0]  ox_q, ox_d;
  logic [9:0]  oy_q, oy_d;
  logic        en_q, en_d;
  logic        mir_q, mir_d;
  logic        hit1_q, hit1_d;
  logic [12:0] addr_q, addr_d;
  logic        hit2_q, hit2_d;
  logic [3:0]  pix_q, pix_d;
  logic        on_q, on_d;

  logic [10:0] dx, dy;
  logic [12:0] col, row_base;

  always_comb begin
    ox_d  = ox_q;
    oy_d  = oy_q;
    en_d  = en_q;
    mir_d = mir_q;
    if (frame_start) begin
      ox_d = sprite_x;
      oy_d = sprite_y;
      en_d = sprite_en;
`ifdef TREE_FETCH_MIRROR_EN
      mir_d = mirror;
`else
      mir_d = 1'b0;
`endif
    end
  end

  // unsigned wrap makes pixels left of / above the origin huge -> miss
  always_comb begin
    dx = {1'b0, DrawX} - {1'b0, ox_q};
    dy = {1'b0, DrawY} - {1'b0, oy_q};
    hit1_d = blank_n & en_q
           & (dx < 11'(SPR_W))
           & (dy < 11'(SPR_H));
    col = mir_q ? 13'(SPR_W - 1) - {2'b00, dx}
                : {2'b00, dx};
    row_base = {2'b00, dy} * 13'(SPR_W);
    addr_d = hit1_d ? row_base + col : addr_q;
  end

  always_comb begin
    hit2_d = hit1_q;
    pix_d  = hit2_q ? data_Out : TRANSP;
    on_d   = hit2_q & (data_Out != TRANSP);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ox_q   <= '0;
      oy_q   <= '0;
      en_q   <= 1'b0;
      mir_q  <= 1'b0;
      hit1_q <= 1'b0;
      addr_q <= '0;
      hit2_q <= 1'b0;
      pix_q  <= TRANSP;
      on_q   <= 1'b0;
    end else begin
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      en_q   <= en_d;
      mir_q  <= mir_d;
      hit1_q <= hit1_d;
      addr_q <= addr_d;
      hit2_q <= hit2_d;
      pix_q  <= pix_d;
      on_q   <= on_d;
    end
  end

  assign read_address = addr_q;
  assign pixel_index  = pix_q;
  assign pixel_on     = on_q;

endmodule

// File: tb/tb_tree_sprite_fetch.sv
// Bench for tree_sprite_fetch: per-cycle model compare plus literal checks.
// Mirror checks are built only with TREE_FETCH_MIRROR_EN.
module tb_tree_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank_n, frame_start;
  logic [9:0]  sprite_x, sprite_y;
  logic        sprite_en;
`ifdef TREE_FETCH_MIRROR_EN
  logic        mirror;
`endif
  logic [12:0] read_address;
  logic [3:0]  data_Out;
  logic [3:0]  pixel_index;
  logic        pixel_on;

  int n_chk = 0;
  int n_fail = 0;

  tree_sprite_fetch dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .DrawX(DrawX),
    .DrawY(DrawY),
    .blank_n(blank_n),
    .frame_start(frame_start),
    .sprite_x(sprite_x),
    .sprite_y(sprite_y),
    .sprite_en(sprite_en),
`ifdef TREE_FETCH_MIRROR_EN
    .mirror(mirror),
`endif
    .read_address(read_address),
    .data_Out(data_Out),
    .pixel_index(pixel_index),
    .pixel_on(pixel_on)
  );

  always #5 Clk = ~Clk;

  logic [3:0] mem [0:8191];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 4'(i) ^ 4'h7;
  end

  always @(posedge Clk) data_Out <= mem[read_address];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // model: sprite geometry evaluated with signed arithmetic
  int  m_ox = 0, m_oy = 0, m_addr = 0;
  bit  m_en = 0, m_mir = 0;
  bit  e_on [8];
  int  e_idx [8];
  int  cyc = 0;
  int  last_rst = -100;

  task automatic model_step();
    int dx, dy, a, slot;
    bit hit;
    slot = cyc % 8;
    if (!Reset_n) begin
      m_ox = 0; m_oy = 0; m_en = 0; m_mir = 0; m_addr = 0;
      last_rst = cyc;
      e_on[slot] = 0; e_idx[slot] = 0;
    end else begin
      dx = int'(DrawX) - m_ox;
      dy = int'(DrawY) - m_oy;
      hit = blank_n && m_en && dx >= 0 && dx < 80 && dy >= 0 && dy < 100;
      a = dy * 80 + (m_mir ? 79 - dx : dx);
      if (hit) m_addr = a;
      e_on[slot]  = hit && (mem[a] != 4'h0);
      e_idx[slot] = hit ? int'(mem[a]) : 0;
      if (frame_start) begin
        m_ox = int'(sprite_x);
        m_oy = int'(sprite_y);
        m_en = sprite_en;
`ifdef TREE_FETCH_MIRROR_EN
        m_mir = mirror;
`endif
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  initial forever begin
    @(negedge Clk);
    if (cyc >= 3) begin
      if (!Reset_n) begin
        chk("m_addr_rst", int'(read_address), 0);
        chk("m_on_rst", int'(pixel_on), 0);
        chk("m_idx_rst", int'(pixel_index), 0);
      end else begin
        chk("m_addr", int'(read_address), m_addr);
        if (last_rst >= cyc - 3) begin
          chk("m_on_flush", int'(pixel_on), 0);
          chk("m_idx_flush", int'(pixel_index), 0);
        end else begin
          chk("m_on", int'(pixel_on), int'(e_on[(cyc - 3) % 8]));
          chk("m_idx", int'(pixel_index), e_idx[(cyc - 3) % 8]);
        end
      end
    end
  end

  task automatic px(input int x, input int y, input bit b, input bit fs);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank_n = b;
    frame_start = fs;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic idle();
    px(0, 0, 0, 0);
  endtask

  task automatic origin(input int x, input int y, input bit en);
    sprite_x = 10'(x);
    sprite_y = 10'(y);
    sprite_en = en;
    px(0, 0, 0, 1);
  endtask

  initial begin
    Reset_n = 1'b0;
    DrawX = '0; DrawY = '0; blank_n = 0; frame_start = 0;
    sprite_x = '0; sprite_y = '0; sprite_en = 0;
`ifdef TREE_FETCH_MIRROR_EN
    mirror = 0;
`endif
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_addr", int'(read_address), 0);
    chk("rst_on", int'(pixel_on), 0);
    chk("rst_idx", int'(pixel_index), 0);
    #2 Reset_n = 1'b1;

    origin(100, 50, 1);
    px(100, 50, 1, 0);
    chk("first_addr", int'(read_address), 0);
    idle(); idle();
    chk("first_on", int'(pixel_on), 1);
    chk("first_idx", int'(pixel_index), 7);

    px(179, 149, 1, 0);
    chk("last_addr", int'(read_address), 7999);
    px(180, 149, 1, 0);
    chk("x_edge_hold", int'(read_address), 7999);
    px(179, 150, 1, 0);
    chk("y_edge_hold", int'(read_address), 7999);
    chk("last_on", int'(pixel_on), 1);
    chk("last_idx", int'(pixel_index), 8);
    idle();
    chk("x_edge_on", int'(pixel_on), 0);
    chk("x_edge_idx", int'(pixel_index), 0);
    idle();
    chk("y_edge_on", int'(pixel_on), 0);

    px(107, 50, 1, 0);
    chk("transp_addr", int'(read_address), 7);
    idle(); idle();
    chk("transp_on", int'(pixel_on), 0);
    px(101, 50, 0, 0);
    idle(); idle();
    chk("blank_on", int'(pixel_on), 0);

    sprite_x = 10'd200;
    px(100, 60, 1, 0);
    chk("mid_old_hit", int'(read_address), 800);
    px(200, 60, 1, 0);
    chk("mid_new_miss", int'(read_address), 800);
    idle();
    chk("mid_old_on", int'(pixel_on), 1);
    idle();
    chk("mid_new_on", int'(pixel_on), 0);
    px(100, 61, 1, 1);
    chk("fs_prelatch", int'(read_address), 880);
    px(100, 61, 1, 0);
    px(205, 61, 1, 0);
    chk("fs_new_addr", int'(read_address), 885);
    chk("fs_old_on", int'(pixel_on), 1);
    idle();
    chk("fs_old_gone", int'(pixel_on), 0);
    idle();
    chk("fs_new_idx", int'(pixel_index), 2);

    origin(600, 450, 1);
    px(639, 479, 1, 0);
    chk("clip_addr", int'(read_address), 2359);
    px(0, 450, 1, 0);
    chk("nowrap", int'(read_address), 2359);
    px(638, 450, 1, 0);
    idle(); idle();
    chk("clip_on", int'(pixel_on), 1);
    chk("clip_idx", int'(pixel_index), 1);

    px(600, 450, 1, 0);
    chk("pre_rst_addr", int'(read_address), 0);
    idle(); idle();
    chk("pre_rst_on", int'(pixel_on), 1);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_on", int'(pixel_on), 0);
    chk("async_idx", int'(pixel_index), 0);
    chk("async_addr", int'(read_address), 0);
    @(negedge Clk);
    @(negedge Clk);
    #2 Reset_n = 1'b1;
    px(600, 450, 1, 0);
    px(610, 455, 1, 0);
    idle();
    chk("post_rst_off", int'(pixel_on), 0);
    idle();
    chk("post_rst_off2", int'(pixel_on), 0);
    chk("post_rst_addr", int'(read_address), 0);
    origin(100, 50, 1);
    px(100, 50, 1, 0);
    idle(); idle();
    chk("relatch_on", int'(pixel_on), 1);

`ifdef TREE_FETCH_MIRROR_EN
    mirror = 1'b1;
    origin(100, 50, 1);
    px(100, 50, 1, 0);
    chk("mirror_addr", int'(read_address), 79);
    px(179, 50, 1, 0);
    chk("mirror_addr_r", int'(read_address), 0);
    mirror = 1'b0;
    origin(100, 50, 1);
`endif

    for (int yi = 0; yi < 4; yi++) begin
      for (int x = 95; x < 186; x += 3) begin
        px(x, (yi == 0) ? 49 : (yi == 1) ? 50 : (yi == 2) ? 149 : 150,
           (x % 7) != 0, 0);
      end
    end
    idle(); idle(); idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
